// File: rtl/uart_pkg.sv
// Shared types for the FIFO-fed UART transmitter: run-time parity selection and
// the transmit FSM state encoding.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2,
        PAR_RSVD = 2'd3
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // The reserved encoding behaves exactly like "no parity".
    function automatic logic parity_enabled(input parity_mode_t mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the transmitter. Full/empty are judged on the
// pre-edge count, so a write while full is dropped and a pop while empty is ignored.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     write,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_write;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_write = write && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)   rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_write) - CW'(do_pop);
        end
    end

    // Storage carries no reset; entries are only read after being written.
    always_ff @(posedge clock) begin
        if (do_write) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// FIFO-fed UART transmitter: queued words go out back-to-back on tx, with
// run-time parity and stop-bit selection latched at each frame start.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TICK_DIV   = 326,
    parameter int OVERSAMPLE = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          tx_start,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    tx_state_t            state, state_next;
    parity_mode_t         mode_q, mode_next;
    logic                 two_stop_q, stop2_next;
    logic                 parity_q, parity_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [3:0]           bit_idx, bit_next;
    logic [TW-1:0]        tick_cnt, tick_next;
    logic [OW-1:0]        os_cnt, os_next;
    logic                 tx_next, busy_next, done_next;
    logic                 load;
    logic                 bit_end;
    logic [DATA_BITS-1:0] fifo_data;

    // tx_start is a strobe with no ready: fifo_full is the producer's only
    // backpressure, and a strobe while full is lost and flagged in overflow.
    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .write    (tx_start),
        .pop      (load),
        .data_in  (data_in),
        .data_out (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign bit_end = (tick_cnt == TW'(TICK_DIV - 1)) && (os_cnt == OW'(OVERSAMPLE - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            shift      <= '0;
            bit_idx    <= '0;
            tick_cnt   <= '0;
            os_cnt     <= '0;
            mode_q     <= PAR_NONE;
            two_stop_q <= 1'b0;
            parity_q   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            tx         <= tx_next;
            tx_busy    <= busy_next;
            tx_done    <= done_next;
            shift      <= shift_next;
            bit_idx    <= bit_next;
            tick_cnt   <= tick_next;
            os_cnt     <= os_next;
            mode_q     <= mode_next;
            two_stop_q <= stop2_next;
            parity_q   <= parity_next;
            overflow   <= overflow | (tx_start & fifo_full);
        end
    end

    always_comb begin
        state_next  = state;
        tx_next     = tx;
        busy_next   = tx_busy;
        done_next   = 1'b0;
        shift_next  = shift;
        bit_next    = bit_idx;
        mode_next   = mode_q;
        stop2_next  = two_stop_q;
        parity_next = parity_q;
        tick_next   = tick_cnt;
        os_next     = os_cnt;
        load        = 1'b0;

        case (state)
            IDLE: begin
                load = !fifo_empty;
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    tx_next    = shift[0];
                    bit_next   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 4'(DATA_BITS - 1)) begin
                        if (parity_enabled(mode_q)) begin
                            state_next = PARITY;
                            tx_next    = parity_q;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                            bit_next   = '0;
                        end
                    end else begin
                        shift_next = shift >> 1;
                        tx_next    = shift[1];
                        bit_next   = bit_idx + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                    bit_next   = '0;
                end
            end
            STOP: begin
                // bit_idx counts stop bits already sent in this state.
                if (bit_end) begin
                    if (two_stop_q && bit_idx == 4'd0) begin
                        bit_next = 4'd1;
                    end else begin
                        done_next = 1'b1;
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                            busy_next  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Frame start: configuration and parity are captured here only.
        if (load) begin
            state_next  = START;
            tx_next     = 1'b0;
            busy_next   = 1'b1;
            shift_next  = fifo_data;
            bit_next    = '0;
            mode_next   = parity_mode_t'(parity_mode);
            stop2_next  = two_stop;
            parity_next = (^fifo_data) ^ (parity_mode == 2'd2);
        end

        if (load || state == IDLE || bit_end) begin
            tick_next = '0;
            os_next   = '0;
        end else if (tick_cnt == TW'(TICK_DIV - 1)) begin
            tick_next = '0;
            os_next   = os_cnt + OW'(1);
        end else begin
            tick_next = tick_cnt + TW'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: per-cycle line capture compared against an
// expected bit-slot waveform derived from the queued words and their framing.
module tb_uart_tx_fifo_param;

    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int TICK_DIV   = 3;
    localparam int OVERSAMPLE = 4;
    localparam int BIT        = TICK_DIV * OVERSAMPLE;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [DATA_BITS-1:0] data_in = '0;
    logic                 tx_start = 1'b0;
    logic [1:0]           parity_mode = 2'd0;
    logic                 two_stop = 1'b0;
    logic                 tx, tx_busy, tx_done, fifo_full, fifo_empty, overflow;
    logic [CW-1:0]        fifo_count;

    uart_tx_fifo_param #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TICK_DIV   (TICK_DIV),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .tx_start    (tx_start),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    // One log entry per falling edge; index = falling-edge number.
    logic tx_log[$];
    logic done_log[$];
    logic busy_log[$];

    always @(negedge clock) begin
        tx_log.push_back(tx);
        done_log.push_back(tx_done);
        busy_log.push_back(tx_busy);
    end

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [DATA_BITS-1:0] w;
        logic [1:0]           pm;
        logic                 ts;
    } frame_t;

    frame_t frame_q[$];
    logic   slot_tx[$];
    logic   slot_done[$];
    logic   slot_busy[$];

    function automatic void add_frame(input logic [DATA_BITS-1:0] w, input logic [1:0] pm, input logic ts);
        frame_t fr;
        fr.w  = w;
        fr.pm = pm;
        fr.ts = ts;
        frame_q.push_back(fr);
    endfunction

    // Reference: each frame is start, LSB-first data, optional parity, stops;
    // frames abut, tx_done marks the first cycle after each frame.
    function automatic void build_slots();
        int   ones;
        logic pb;
        slot_tx.delete();
        slot_done.delete();
        slot_busy.delete();
        foreach (frame_q[f]) begin
            ones = 0;
            slot_tx.push_back(1'b0);
            slot_done.push_back(f != 0);
            slot_busy.push_back(1'b1);
            for (int i = 0; i < DATA_BITS; i++) begin
                slot_tx.push_back(frame_q[f].w[i]);
                slot_done.push_back(1'b0);
                slot_busy.push_back(1'b1);
                ones += int'(frame_q[f].w[i]);
            end
            if (frame_q[f].pm == 2'd1 || frame_q[f].pm == 2'd2) begin
                pb = (ones % 2 == 1);
                if (frame_q[f].pm == 2'd2) pb = !pb;
                slot_tx.push_back(pb);
                slot_done.push_back(1'b0);
                slot_busy.push_back(1'b1);
            end
            for (int k = 0; k < (frame_q[f].ts ? 2 : 1); k++) begin
                slot_tx.push_back(1'b1);
                slot_done.push_back(1'b0);
                slot_busy.push_back(1'b1);
            end
        end
        for (int k = 0; k < 2; k++) begin
            slot_tx.push_back(1'b1);
            slot_done.push_back(k == 0 && frame_q.size() != 0);
            slot_busy.push_back(1'b0);
        end
    endfunction

    task automatic push(input logic [DATA_BITS-1:0] w, output int at);
        @(negedge clock);
        #1;
        data_in  = w;
        tx_start = 1'b1;
        at = tx_log.size() - 1;
    endtask

    task automatic idle();
        @(negedge clock);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        n_cmp++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_line: got tx=%b busy=%b done=%b, want 1 0 0", tx, tx_busy, tx_done);
        end
        n_cmp++;
        if (fifo_count !== CW'(0) || fifo_empty !== 1'b1 || fifo_full !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_fifo: got count=%0d empty=%b full=%b ovf=%b, want 0 1 0 0",
                     fifo_count, fifo_empty, fifo_full, overflow);
        end
        reset = 1'b1;
        repeat (4) @(negedge clock);
        #1;
        n_cmp++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            n_err++;
            $display("FAIL release_line: got tx=%b busy=%b done=%b, want 1 0 0", tx, tx_busy, tx_done);
        end
        n_cmp++;
        if (fifo_count !== CW'(0) || fifo_empty !== 1'b1 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL release_fifo: got count=%0d empty=%b ovf=%b, want 0 1 0", fifo_count, fifo_empty, overflow);
        end
    endtask

    task automatic test_8n1();
        int at, s, dones;
        apply_reset();
        parity_mode = 2'd0;
        two_stop    = 1'b0;
        push(8'h55, at);
        idle();
        s = at + 2;
        frame_q.delete();
        add_frame(8'h55, 2'd0, 1'b0);
        build_slots();
        while (tx_log.size() < s + slot_tx.size() * BIT) @(negedge clock);
        n_cmp++;
        if (tx_log[at + 1] !== 1'b1 || tx_log[at + 2] !== 1'b0) begin
            n_err++;
            $display("FAIL latency: tx after k=%b after k+1=%b, want 1 then 0", tx_log[at + 1], tx_log[at + 2]);
        end
        dones = 0;
        for (int i = at; i < s + slot_tx.size() * BIT; i++) dones += int'(done_log[i]);
        n_cmp++;
        if (dones != 1 || done_log[s + 10 * BIT] !== 1'b1) begin
            n_err++;
            $display("FAIL done_8n1: got %0d pulses, done at fall+10*BIT=%b, want 1 and 1", dones, done_log[s + 10 * BIT]);
        end
        for (int j = 0; j < slot_tx.size(); j++) begin
            int bad;
            int base;
            bad  = 0;
            base = s + j * BIT;
            for (int c = 0; c < BIT; c++) begin
                if (tx_log[base + c] !== slot_tx[j]) bad++;
                if (busy_log[base + c] !== slot_busy[j]) bad++;
                if (c != 0 && done_log[base + c] !== 1'b0) bad++;
            end
            n_cmp++;
            if (bad != 0 || done_log[base] !== slot_done[j]) begin
                n_err++;
                $display("FAIL 8n1 slot %0d: want tx=%b busy=%b done=%b, got %0d bad cycles done=%b",
                         j, slot_tx[j], slot_busy[j], slot_done[j], bad, done_log[base]);
            end
        end
    endtask

    task automatic test_parity();
        logic [DATA_BITS-1:0] words [3] = '{8'hAA, 8'h07, 8'h07};
        logic [1:0]           modes [3] = '{2'd1, 2'd2, 2'd1};
        logic                 pbits [3] = '{1'b0, 1'b0, 1'b1};
        int at, s;
        for (int t = 0; t < 3; t++) begin
            parity_mode = modes[t];
            two_stop    = 1'b0;
            push(words[t], at);
            idle();
            s = at + 2;
            frame_q.delete();
            add_frame(words[t], modes[t], 1'b0);
            build_slots();
            while (tx_log.size() < s + slot_tx.size() * BIT) @(negedge clock);
            n_cmp++;
            if (tx_log[s + 9 * BIT + BIT / 2] !== pbits[t] || done_log[s + 11 * BIT] !== 1'b1) begin
                n_err++;
                $display("FAIL parity_bit case %0d: got parity=%b done@11=%b, want %b and 1",
                         t, tx_log[s + 9 * BIT + BIT / 2], done_log[s + 11 * BIT], pbits[t]);
            end
            for (int j = 0; j < slot_tx.size(); j++) begin
                int bad;
                int base;
                bad  = 0;
                base = s + j * BIT;
                for (int c = 0; c < BIT; c++) begin
                    if (tx_log[base + c] !== slot_tx[j]) bad++;
                    if (busy_log[base + c] !== slot_busy[j]) bad++;
                    if (c != 0 && done_log[base + c] !== 1'b0) bad++;
                end
                n_cmp++;
                if (bad != 0 || done_log[base] !== slot_done[j]) begin
                    n_err++;
                    $display("FAIL parity case %0d slot %0d: want tx=%b busy=%b done=%b, got %0d bad cycles done=%b",
                             t, j, slot_tx[j], slot_busy[j], slot_done[j], bad, done_log[base]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_BITS-1:0] w;
        int at, a, s, dones;
        apply_reset();
        parity_mode = 2'd0;
        two_stop    = 1'b0;
        frame_q.delete();
        for (int k = 0; k < 6; k++) begin
            w = DATA_BITS'($urandom);
            push(w, a);
            if (k == 0) at = a;
            if (k < FIFO_DEPTH + 1) add_frame(w, 2'd0, 1'b0);
        end
        idle();
        n_cmp++;
        if (fifo_count !== CW'(FIFO_DEPTH) || fifo_full !== 1'b1 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL burst_fifo: got count=%0d full=%b ovf=%b, want %0d 1 1",
                     fifo_count, fifo_full, overflow, FIFO_DEPTH);
        end
        s = at + 2;
        build_slots();
        while (tx_log.size() < s + slot_tx.size() * BIT) @(negedge clock);
        dones = 0;
        for (int i = at; i < s + slot_tx.size() * BIT; i++) dones += int'(done_log[i]);
        n_cmp++;
        if (dones != FIFO_DEPTH + 1 || overflow !== 1'b1 || fifo_empty !== 1'b1) begin
            n_err++;
            $display("FAIL burst_done: got %0d pulses ovf=%b empty=%b, want %0d 1 1",
                     dones, overflow, fifo_empty, FIFO_DEPTH + 1);
        end
        for (int j = 0; j < slot_tx.size(); j++) begin
            int bad;
            int base;
            bad  = 0;
            base = s + j * BIT;
            for (int c = 0; c < BIT; c++) begin
                if (tx_log[base + c] !== slot_tx[j]) bad++;
                if (busy_log[base + c] !== slot_busy[j]) bad++;
                if (c != 0 && done_log[base + c] !== 1'b0) bad++;
            end
            n_cmp++;
            if (bad != 0 || done_log[base] !== slot_done[j]) begin
                n_err++;
                $display("FAIL burst slot %0d: want tx=%b busy=%b done=%b, got %0d bad cycles done=%b",
                         j, slot_tx[j], slot_busy[j], slot_done[j], bad, done_log[base]);
            end
        end
    endtask

    task automatic test_two_stop();
        logic [DATA_BITS-1:0] w0, w1;
        int at, a, s, high;
        apply_reset();
        parity_mode = 2'd0;
        two_stop    = 1'b1;
        w0 = DATA_BITS'($urandom);
        w1 = DATA_BITS'($urandom);
        push(w0, at);
        push(w1, a);
        idle();
        s = at + 2;
        while (tx_log.size() < s + 3 * BIT) @(negedge clock);
        #1;
        two_stop    = 1'b0;
        parity_mode = 2'd1;
        frame_q.delete();
        add_frame(w0, 2'd0, 1'b1);
        add_frame(w1, 2'd1, 1'b0);
        build_slots();
        while (tx_log.size() < s + slot_tx.size() * BIT) @(negedge clock);
        high = 0;
        while (high < 5 * BIT && tx_log[s + 9 * BIT + high] === 1'b1) high++;
        n_cmp++;
        if (high != 2 * BIT) begin
            n_err++;
            $display("FAIL two_stop_gap: got %0d high cycles, want %0d", high, 2 * BIT);
        end
        for (int j = 0; j < slot_tx.size(); j++) begin
            int bad;
            int base;
            bad  = 0;
            base = s + j * BIT;
            for (int c = 0; c < BIT; c++) begin
                if (tx_log[base + c] !== slot_tx[j]) bad++;
                if (busy_log[base + c] !== slot_busy[j]) bad++;
                if (c != 0 && done_log[base + c] !== 1'b0) bad++;
            end
            n_cmp++;
            if (bad != 0 || done_log[base] !== slot_done[j]) begin
                n_err++;
                $display("FAIL two_stop slot %0d: want tx=%b busy=%b done=%b, got %0d bad cycles done=%b",
                         j, slot_tx[j], slot_busy[j], slot_done[j], bad, done_log[base]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int at, a, s, rel, bad;
        apply_reset();
        parity_mode = 2'd0;
        two_stop    = 1'b0;
        push(8'hF0, at);
        push(8'h3C, a);
        push(8'hC3, a);
        idle();
        s = at + 2;
        while (tx_log.size() < s + 3 * BIT + 4) @(negedge clock);
        #1;
        n_cmp++;
        if (fifo_count !== CW'(2) || tx_busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_before_reset: got count=%0d busy=%b, want 2 1", fifo_count, tx_busy);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (tx !== 1'b1 || fifo_count !== CW'(0) || fifo_empty !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got tx=%b count=%0d empty=%b busy=%b done=%b, want 1 0 1 0 0",
                     tx, fifo_count, fifo_empty, tx_busy, tx_done);
        end
        @(negedge clock);
        #1;
        reset = 1'b1;
        rel = tx_log.size() - 1;
        while (tx_log.size() < rel + 4 * BIT) @(negedge clock);
        bad = 0;
        for (int i = rel; i < rel + 4 * BIT; i++) begin
            if (tx_log[i] !== 1'b1 || done_log[i] !== 1'b0 || busy_log[i] !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0 || fifo_empty !== 1'b1 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset_quiet: got %0d bad cycles empty=%b ovf=%b, want 0 1 0", bad, fifo_empty, overflow);
        end
    endtask

    task automatic test_random();
        logic [DATA_BITS-1:0] w;
        logic [1:0]           pm;
        logic                 ts;
        int n, at, a, s, exp_count;
        for (int r = 0; r < 6; r++) begin
            n  = $urandom_range(1, 3);
            pm = 2'($urandom_range(0, 3));
            ts = 1'($urandom_range(0, 1));
            parity_mode = pm;
            two_stop    = ts;
            frame_q.delete();
            for (int k = 0; k < n; k++) begin
                w = DATA_BITS'($urandom);
                push(w, a);
                if (k == 0) at = a;
                add_frame(w, pm, ts);
            end
            idle();
            exp_count = (n == 1) ? 1 : n - 1;
            n_cmp++;
            if (fifo_count !== CW'(exp_count)) begin
                n_err++;
                $display("FAIL random round %0d count: got %0d, want %0d", r, fifo_count, exp_count);
            end
            s = at + 2;
            build_slots();
            while (tx_log.size() < s + slot_tx.size() * BIT) @(negedge clock);
            for (int j = 0; j < slot_tx.size(); j++) begin
                int bad;
                int base;
                bad  = 0;
                base = s + j * BIT;
                for (int c = 0; c < BIT; c++) begin
                    if (tx_log[base + c] !== slot_tx[j]) bad++;
                    if (busy_log[base + c] !== slot_busy[j]) bad++;
                    if (c != 0 && done_log[base + c] !== 1'b0) bad++;
                end
                n_cmp++;
                if (bad != 0 || done_log[base] !== slot_done[j]) begin
                    n_err++;
                    $display("FAIL random round %0d slot %0d: want tx=%b busy=%b done=%b, got %0d bad cycles done=%b",
                             r, j, slot_tx[j], slot_busy[j], slot_done[j], bad, done_log[base]);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_two_stop();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
Parametrised successor to the single-byte UART transmitter system. Queues words in an internal FIFO and serialises them back-to-back on `tx`. Data width is configurable at build time; parity and stop-bit count are selectable at run time. Sits between any byte producer and the board UART pin, and reuses the 16x-oversampled baud-tick scheme of the existing transmitter.

Parameters:
DATA_BITS, 8, payload bits per frame; legal range 5..9.
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.
TICK_DIV, 326, clock cycles per oversample tick (100 MHz, about 19200 baud).
OVERSAMPLE, 16, ticks per UART bit; bit period BIT = OVERSAMPLE*TICK_DIV = 5216 cycles at defaults.

Ports:
clock  input  1  system clock, all logic on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
data_in  input  DATA_BITS  word to enqueue.
tx_start  input  1  write strobe; enqueues data_in on the edge where it is sampled high.
parity_mode  input  2  0 none, 1 even, 2 odd, 3 treated as none.
two_stop  input  1  0 = one stop bit, 1 = two stop bits.
tx  output  1  serial line; idles high.
tx_busy  output  1  high while a frame is being shifted out.
tx_done  output  1  one-cycle pulse at the end of each frame's last stop bit.
fifo_full  output  1  count == FIFO_DEPTH.
fifo_empty  output  1  count == 0.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow  output  1  sticky; set when tx_start arrives while full. Cleared only by reset.

Behaviour:
- Reset (reset==0, asynchronous): tx=1, tx_busy=0, tx_done=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0. FSM goes to IDLE and tick/bit counters clear. A frame in flight is abandoned with no tx_done.
- Write rule: tx_start high and !fifo_full → data_in written, count+1. Fullness is evaluated before any same-cycle pop, so there is no write-through when full. A write while full is dropped and sets overflow.
- Simultaneous write and pop: count unchanged. A write to an empty FIFO is never popped in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when !fifo_empty, pop on that edge, load the shift register, latch parity_mode and two_stop, set tx=0 and tx_busy=1, clear the tick and bit counters, and go to START.
- Latency: tx_start sampled at edge k → tx falls after edge k+1.
- Every bit, including start and stop bits, lasts exactly BIT cycles (OVERSAMPLE ticks of TICK_DIV cycles each). The tick counter restarts at each frame start.
- START → DATA after BIT cycles.
- DATA: DATA_BITS bits, LSB first.
- DATA → PARITY if the latched mode is 1 or 2, otherwise → STOP.
- PARITY bit: even = XOR of the data bits; odd = inverted XOR. Then → STOP.
- STOP: tx=1 for one or two BIT periods, according to the latched two_stop.
- End of last stop bit: tx_done=1 for that single cycle. If the FIFO is non-empty, pop and enter START on the same edge (zero idle cycles between frames). Otherwise go to IDLE and set tx_busy=0.
- Config changes mid-frame have no effect until the next frame start.
- Frame length = (1 + DATA_BITS + P + S) * BIT cycles, with P in {0,1} and S in {1,2}.

Decomposition:
- Shared package uart_pkg: parity_mode_t enum (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD) and tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
- One sub-module: uart_tx_fifo, a synchronous FIFO with write, pop, full, empty and count.
- Baud tick and bit counters are kept inline in the top module.

Test Plan:
- Reset with reset=0, then reset=1 → tx=1, fifo_empty=1, fifo_count=0, tx_busy=0, overflow=0.
- 8N1: write 0x55 → start bit, then bits 1,0,1,0,1,0,1,0 each 5216 cycles, then stop. tx_done pulses once, 52160 cycles after tx falls.
- Parity: 0xAA even → parity bit 0 (11-bit frame). 0x07 odd → parity bit 0. 0x07 even → parity bit 1.
- Burst: 6 consecutive tx_start with DEPTH=4 → word 1 popped immediately, words 2-5 queued, word 6 dropped. overflow=1. Five frames back-to-back with no idle gap; five tx_done pulses.
- two_stop=1, two queued words → tx high for exactly 10432 cycles between the end of the last data bit and the next start bit.
- Assert reset mid-DATA with 2 words queued → tx=1 immediately (asynchronous), fifo_count=0, no tx_done. After release, tx stays high.
